// File: rtl/uart_prot_rx.sv
// 8N1 UART receiver feeding data_comp: 2-flop RX synchronizer, falling-edge start detect, mid-bit sampling.
// Optional even-parity bit between data and stop when PARITY_CHK_EN is defined; otherwise par_err is tied low.
module uart_prot_rx #(
   parameter int BAUD_W = 16,
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              RX,
   input  logic [BAUD_W-1:0] baud_cnt,
   output logic [DATA_W-1:0] serial_data,
   output logic              serial_vld,
   output logic              frm_err,
   output logic              par_err,
   output logic              busy
);

   localparam int IDX_W = $clog2(DATA_W);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
`ifdef PARITY_CHK_EN
      S_PARITY,
`endif
      S_STOP
   } state_t;

   state_t            state_q;
   logic              rx_meta_q;
   logic              rx_s_q;
   logic              rx_prev_q;
   logic [BAUD_W-1:0] cnt_q;
   logic [BAUD_W-1:0] eff_q;
   logic [BAUD_W-1:0] eff_d;
   logic [DATA_W-1:0] shift_q;
   logic [DATA_W-1:0] data_q;
   logic [IDX_W-1:0]  bit_idx_q;
   logic              vld_q;
   logic              frm_q;
   logic              start_edge;
   logic              tick;
`ifdef PARITY_CHK_EN
   logic              par_bad_q;
   logic              par_q;
`endif

   // Periods below 2 would leave no room for the half-bit offset to the sample point.
   assign eff_d      = (baud_cnt < BAUD_W'(2)) ? BAUD_W'(2) : baud_cnt;
   assign start_edge = rx_prev_q & ~rx_s_q;
   assign tick       = (cnt_q == '0);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         rx_meta_q <= 1'b1;
         rx_s_q    <= 1'b1;
         rx_prev_q <= 1'b1;
         cnt_q     <= '0;
         eff_q     <= BAUD_W'(2);
         shift_q   <= '0;
         data_q    <= '0;
         bit_idx_q <= '0;
         vld_q     <= 1'b0;
         frm_q     <= 1'b0;
`ifdef PARITY_CHK_EN
         par_bad_q <= 1'b0;
         par_q     <= 1'b0;
`endif
      end else begin
         rx_meta_q <= RX;
         rx_s_q    <= rx_meta_q;
         rx_prev_q <= rx_s_q;
         vld_q     <= 1'b0;
         frm_q     <= 1'b0;
`ifdef PARITY_CHK_EN
         par_q     <= 1'b0;
`endif
         case (state_q)
            S_IDLE: begin
               if (start_edge) begin
                  eff_q   <= eff_d;
                  cnt_q   <= (eff_d >> 1) - BAUD_W'(1);
                  state_q <= S_START;
               end
            end
            S_START: begin
               if (!tick) begin
                  cnt_q <= cnt_q - BAUD_W'(1);
               end else if (rx_s_q) begin
                  state_q <= S_IDLE;
               end else begin
                  cnt_q     <= eff_q - BAUD_W'(1);
                  bit_idx_q <= '0;
                  state_q   <= S_DATA;
               end
            end
            S_DATA: begin
               if (!tick) begin
                  cnt_q <= cnt_q - BAUD_W'(1);
               end else begin
                  shift_q   <= {rx_s_q, shift_q[DATA_W-1:1]};
                  bit_idx_q <= bit_idx_q + IDX_W'(1);
                  cnt_q     <= eff_q - BAUD_W'(1);
                  if (bit_idx_q == IDX_W'(DATA_W - 1)) begin
`ifdef PARITY_CHK_EN
                     state_q <= S_PARITY;
`else
                     state_q <= S_STOP;
`endif
                  end
               end
            end
`ifdef PARITY_CHK_EN
            S_PARITY: begin
               if (!tick) begin
                  cnt_q <= cnt_q - BAUD_W'(1);
               end else begin
                  par_bad_q <= rx_s_q ^ (^shift_q);
                  cnt_q     <= eff_q - BAUD_W'(1);
                  state_q   <= S_STOP;
               end
            end
`endif
            S_STOP: begin
               if (!tick) begin
                  cnt_q <= cnt_q - BAUD_W'(1);
               end else begin
                  state_q <= S_IDLE;
`ifdef PARITY_CHK_EN
                  par_q <= par_bad_q;
                  if (rx_s_q && !par_bad_q) begin
`else
                  if (rx_s_q) begin
`endif
                     data_q <= shift_q;
                     vld_q  <= 1'b1;
                  end else if (!rx_s_q) begin
                     frm_q <= 1'b1;
                  end
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign serial_data = data_q;
   assign serial_vld  = vld_q;
   assign frm_err     = frm_q;
   assign busy        = (state_q != S_IDLE);
`ifdef PARITY_CHK_EN
   assign par_err     = par_q;
`else
   assign par_err     = 1'b0;
`endif

endmodule

// File: tb/tb_uart_prot_rx.sv
// Self-checking bench for uart_prot_rx: vector table, hand-written corner sequences, randomized frames vs. a frame-level model.
module tb_uart_prot_rx;

   logic        clk = 1'b0;
   logic        rst;
   logic        RX;
   logic [15:0] baud_cnt;
   logic [7:0]  serial_data;
   logic        serial_vld;
   logic        frm_err;
   logic        par_err;
   logic        busy;

`ifdef PARITY_CHK_EN
   localparam bit PAR = 1'b1;
`else
   localparam bit PAR = 1'b0;
`endif

   always #5 clk = ~clk;

   uart_prot_rx #(.BAUD_W(16), .DATA_W(8)) dut (
      .clk(clk), .rst(rst), .RX(RX), .baud_cnt(baud_cnt),
      .serial_data(serial_data), .serial_vld(serial_vld),
      .frm_err(frm_err), .par_err(par_err), .busy(busy)
   );

   int n_tests = 0;
   int n_fail  = 0;

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int unsigned n_vld = 0, n_frm = 0, n_par = 0, n_busy = 0, n_ovl = 0, vld_cyc = 0;
   logic [7:0]  vld_hist [256];

   always @(negedge clk) begin
      if (serial_vld) begin
         vld_hist[n_vld[7:0]] <= serial_data;
         n_vld   <= n_vld + 1;
         vld_cyc <= cyc;
      end
      if (frm_err) n_frm <= n_frm + 1;
      if (par_err) n_par <= n_par + 1;
      if (busy) n_busy <= n_busy + 1;
      if (serial_vld && frm_err) n_ovl <= n_ovl + 1;
   end

   typedef struct {
      logic [7:0] data;
      bit         stop;
      bit         pbit;
      int         baud;
      int         period;
      bit         e_vld;
      bit         e_frm;
      bit         e_par;
      logic [7:0] e_data;
      int         e_lat;
   } vec_t;

   vec_t vecs [11];

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   task automatic wait_bits(input int p);
      repeat (p) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic idle(input int n);
      RX = 1'b1;
      wait_bits(n);
   endtask

   task automatic send_frame(input logic [7:0] d, input bit stop, input bit pbit, input int p,
                             input int new_baud, output int unsigned t0);
      t0 = cyc;
      RX = 1'b0;
      wait_bits(p);
      for (int i = 0; i < 8; i++) begin
         if (i == 4 && new_baud >= 0) baud_cnt = new_baud[15:0];
         RX = d[i];
         wait_bits(p);
      end
      if (PAR) begin
         RX = pbit;
         wait_bits(p);
      end
      RX = stop;
      wait_bits(p);
   endtask

   task automatic wait_idle(input string name);
      int k = 0;
      while (busy === 1'b1 && k < 3000) begin
         @(posedge clk);
         #1;
         k++;
      end
      check({name, "_idle_timeout"}, 32'(k < 3000), 32'd1);
      wait_bits(3);
   endtask

   initial begin
      int unsigned t0, b_vld, b_frm, b_par, b_busy;
      logic [7:0]  model_data;
      string       nm;

      vecs[0] = '{8'hA5, 1'b1, 1'b0, 16, 16, 1'b1, 1'b0, 1'b0, 8'hA5, 155};
      vecs[1] = '{8'h3C, 1'b0, 1'b0, 16, 16, 1'b0, 1'b1, 1'b0, 8'hA5, 0};
      vecs[2] = '{8'h00, 1'b1, 1'b0,  8,  8, 1'b1, 1'b0, 1'b0, 8'h00, 0};
      vecs[3] = '{8'hFF, 1'b1, 1'b0,  2,  2, 1'b1, 1'b0, 1'b0, 8'hFF, 0};
      vecs[4] = '{8'h3C, 1'b1, 1'b0,  0,  2, 1'b1, 1'b0, 1'b0, 8'h3C, 0};
      vecs[5] = '{8'h81, 1'b1, 1'b0,  1,  2, 1'b1, 1'b0, 1'b0, 8'h81, 0};
      vecs[6] = '{8'h55, 1'b1, 1'b0,  3,  3, 1'b1, 1'b0, 1'b0, 8'h55, 0};
      vecs[7] = '{8'h96, 1'b0, 1'b0,  5,  5, 1'b0, 1'b1, 1'b0, 8'h55, 0};
`ifdef PARITY_CHK_EN
      vecs[8]  = '{8'h07, 1'b1, 1'b0, 16, 16, 1'b0, 1'b0, 1'b1, 8'h55, 0};
      vecs[9]  = '{8'h07, 1'b1, 1'b1, 16, 16, 1'b1, 1'b0, 1'b0, 8'h07, 0};
      vecs[10] = '{8'h01, 1'b0, 1'b0,  6,  6, 1'b0, 1'b1, 1'b1, 8'h07, 0};
`else
      vecs[8]  = '{8'h07, 1'b1, 1'b0, 16, 16, 1'b1, 1'b0, 1'b0, 8'h07, 0};
      vecs[9]  = '{8'h07, 1'b1, 1'b1, 16, 16, 1'b1, 1'b0, 1'b0, 8'h07, 0};
      vecs[10] = '{8'h01, 1'b0, 1'b0,  6,  6, 1'b0, 1'b1, 1'b0, 8'h07, 0};
`endif

      rst      = 1'b1;
      RX       = 1'b1;
      baud_cnt = 16'd16;
      repeat (3) @(posedge clk);
      #1;
      check("rst_data", 32'(serial_data), 32'h00);
      check("rst_vld",  32'(serial_vld),  32'd0);
      check("rst_frm",  32'(frm_err),     32'd0);
      check("rst_par",  32'(par_err),     32'd0);
      check("rst_busy", 32'(busy),        32'd0);
      rst = 1'b0;
      idle(5);

      for (int i = 0; i < 11; i++) begin
         baud_cnt = vecs[i].baud[15:0];
         idle(4);
         b_vld = n_vld; b_frm = n_frm; b_par = n_par;
         send_frame(vecs[i].data, vecs[i].stop, vecs[i].pbit, vecs[i].period, -1, t0);
         RX = 1'b1;
         nm = $sformatf("vec%0d", i);
         wait_idle(nm);
         check({nm, "_vld"},  n_vld - b_vld, 32'(vecs[i].e_vld));
         check({nm, "_frm"},  n_frm - b_frm, 32'(vecs[i].e_frm));
         check({nm, "_par"},  n_par - b_par, 32'(vecs[i].e_par));
         check({nm, "_data"}, 32'(serial_data), 32'(vecs[i].e_data));
         if (vecs[i].e_lat != 0)
            check({nm, "_lat"}, 32'((vld_cyc - t0 + 1 - vecs[i].e_lat) <= 2), 32'd1);
      end

      // Short low glitch: rejected at the mid-start sample.
      baud_cnt = 16'd16;
      idle(4);
      b_vld = n_vld; b_frm = n_frm; b_busy = n_busy;
      RX = 1'b0;
      wait_bits(4);
      RX = 1'b1;
      wait_bits(40);
      check("glitch_busy", n_busy - b_busy, 32'd8);
      check("glitch_vld",  n_vld - b_vld,   32'd0);
      check("glitch_frm",  n_frm - b_frm,   32'd0);
      check("glitch_data", 32'(serial_data), 32'h07);

      // Framing error after a good A5, then line held low: no retrigger.
      send_frame(8'hA5, 1'b1, 1'b0, 16, -1, t0);
      wait_idle("fe_a5");
      b_vld = n_vld; b_frm = n_frm;
      send_frame(8'h3C, 1'b0, 1'b0, 16, -1, t0);
      wait_idle("fe_3c");
      b_busy = n_busy;
      RX = 1'b0;
      wait_bits(100);
      check("fe_frm",   n_frm - b_frm,   32'd1);
      check("fe_vld",   n_vld - b_vld,   32'd0);
      check("fe_data",  32'(serial_data), 32'hA5);
      check("fe_hold_busy", n_busy - b_busy, 32'd0);
      idle(20);

      // Back-to-back frames, baud changed 16->8 in the middle of the first.
      b_vld = n_vld;
      send_frame(8'h0F, 1'b1, 1'b0, 16, 8, t0);
      send_frame(8'hF0, 1'b1, 1'b0, 8, -1, t0);
      RX = 1'b1;
      wait_idle("b2b");
      check("b2b_count", n_vld - b_vld, 32'd2);
      check("b2b_first",  32'(vld_hist[b_vld[7:0]]), 32'h0F);
      check("b2b_second", 32'(vld_hist[8'(b_vld + 1)]), 32'hF0);

      // Reset during data bit 4 of 8'h81.
      baud_cnt = 16'd16;
      idle(4);
      b_vld = n_vld; b_frm = n_frm;
      RX = 1'b0;
      wait_bits(16);
      for (int i = 0; i < 4; i++) begin
         RX = (i == 0);
         wait_bits(16);
      end
      RX = 1'b0;
      wait_bits(8);
      rst = 1'b1;
      RX  = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      check("rstmid_data", 32'(serial_data), 32'h00);
      check("rstmid_busy", 32'(busy), 32'd0);
      check("rstmid_vld",  32'(serial_vld), 32'd0);
      check("rstmid_frm",  32'(frm_err), 32'd0);
      idle(200);
      check("rstmid_nostrobe", (n_vld - b_vld) + (n_frm - b_frm), 32'd0);
      send_frame(8'h55, 1'b1, 1'b0, 16, -1, t0);
      wait_idle("rstmid_55");
      check("rstmid_55_data", 32'(serial_data), 32'h55);
      check("rstmid_55_vld",  n_vld - b_vld, 32'd1);

      // Randomized frames against a frame-level model.
      model_data = 8'h55;
      for (int i = 0; i < 40; i++) begin
         int         b, p;
         logic [7:0] d;
         bit         stop, pbit, e_pbad, e_vld;
         b    = int'($urandom_range(0, 20));
         p    = (b < 2) ? 2 : b;
         d    = 8'($urandom_range(0, 255));
         stop = ($urandom_range(0, 4) != 0);
         pbit = (^d) ^ ($urandom_range(0, 3) == 0);
         e_pbad = PAR && (pbit != (^d));
         e_vld  = stop && !e_pbad;
         if (e_vld) model_data = d;
         baud_cnt = b[15:0];
         idle(3);
         b_vld = n_vld; b_frm = n_frm; b_par = n_par;
         send_frame(d, stop, pbit, p, -1, t0);
         RX = 1'b1;
         nm = $sformatf("rnd%0d", i);
         wait_idle(nm);
         check({nm, "_vld"},  n_vld - b_vld, 32'(e_vld));
         check({nm, "_frm"},  n_frm - b_frm, 32'(!stop));
         check({nm, "_par"},  n_par - b_par, 32'(e_pbad));
         check({nm, "_data"}, 32'(serial_data), 32'(model_data));
      end

      check("vld_frm_overlap", n_ovl, 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/uart_prot_rx.md
Name: uart_prot_rx

Overview:
UART receiver stage that sits directly upstream of data_comp in the protocol-trigger path. It oversamples the asynchronous RX line and deframes 8N1 characters (LSB first). Each good character is presented on serial_data with a one-cycle serial_vld strobe, which data_comp compares against match/mask. Framing errors are flagged and the data register is left unchanged.

Parameters:
BAUD_W, 16, width of the programmable baud-period count (clocks per bit).
DATA_W, 8, character width; fixed at 8 for data_comp compatibility.

Ports:
clk  input  1  system clock; all logic is on the rising edge.
rst  input  1  synchronous, active-high reset.
RX  input  1  asynchronous serial line; idles high.
baud_cnt  input  BAUD_W  clocks per bit period; captured at start-bit detect.
serial_data  output  DATA_W  last correctly received character.
serial_vld  output  1  one-cycle strobe; serial_data is valid in the same cycle.
frm_err  output  1  one-cycle strobe; stop bit was sampled low.
par_err  output  1  one-cycle strobe on parity mismatch (see Optional Feature).
busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset: one clock, synchronous, active-high (rst). On reset:
  - state=IDLE; serial_data=8'h00; serial_vld, frm_err, par_err and busy = 0.
  - Synchronizer flops and the edge-history flop = 1.
  - Reset asserted mid-frame aborts the frame immediately; no strobe is generated.
- Synchronizer: RX passes through 2 flops (rx_s). A third flop holds the previous rx_s. A start edge is prev=1 and rx_s=0.
- Baud counter: eff = max(baud_cnt, 2), captured at start detect. A change to baud_cnt mid-frame is ignored until the next frame.
- Down-counter: the sample point is the cycle the counter equals 0. The counter reloads eff-1 after each sample.
- FSM states: IDLE, START, DATA, STOP (plus PARITY with the macro).
  - IDLE: on a start edge, load the counter with (eff>>1)-1 and go to START. A line that is low with no edge, e.g. held low after a framing error, does not retrigger.
  - START: at the sample point:
    - rx_s=1 means a false start: go to IDLE with no strobe.
    - Otherwise reload the counter, clear bit_idx, and go to DATA.
  - DATA: at each sample point, shift rx_s into the MSB of the shift register (right shift) and increment bit_idx. After the 8th bit, go to STOP (or PARITY).
  - STOP: at the sample point:
    - rx_s=1: serial_data<=shift register, and serial_vld=1 for exactly one cycle.
    - rx_s=0: frm_err=1 for one cycle, and serial_data is held.
    - Either way, go to IDLE in the same cycle.
- Latency: serial_vld rises at the clock edge ending the mid-stop-bit sample cycle. With an ideal line this is about 9.5*eff + 3 clocks after the RX falling edge.
- Back-to-back frames: a new start edge may occur one cycle after returning to IDLE. Minimum stop length is 0.5 bit.
- serial_vld and frm_err are mutually exclusive. The strobes never overlap reset.

Optional Feature:
Macro PARITY_CHK_EN.
- Defined:
  - A PARITY state is inserted between DATA and STOP, sampling one even-parity bit.
  - On mismatch, STOP still completes. serial_vld is suppressed and serial_data is held.
  - par_err pulses for one cycle at the stop sample; frm_err may assert simultaneously.
- Undefined:
  - The frame is 8N1.
  - The par_err port exists but is tied to 0.

Test Plan:
- baud_cnt=16; send 8'hA5, 8N1 -> exactly one serial_vld pulse, serial_data=8'hA5, about 155 clocks after the falling edge; frm_err=0; busy returns to 0.
- RX low glitch of 4 clocks at baud_cnt=16 -> START rejects it; no strobe; busy=1 for about 8 cycles, then 0; serial_data unchanged.
- Send 8'h3C with stop bit 0 after a prior 8'hA5 -> frm_err one-cycle pulse; serial_vld=0; serial_data stays 8'hA5. Holding RX low afterwards gives no retrigger.
- Back-to-back 8'h0F then 8'hF0 with a single stop bit each; baud_cnt changed 16->8 during the first frame -> two serial_vld pulses with values 0F then F0. The first frame completes at period 16; the second runs at period 8.
- Assert rst during data bit 4 of 8'h81 -> all outputs 0 and serial_data=00 in the next cycle; a subsequent 8'h55 frame is received correctly.
- PARITY_CHK_EN defined; send 8'h07 with parity bit 0 -> par_err pulse, no serial_vld. Same data with parity bit 1 -> serial_vld, serial_data=8'h07.
